// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice per cycle, LSB first, result in z/co.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting x - y.
//
// state | meaning
// IDLE  | no result held, waiting for start
// RUN   | one sum bit produced per cycle
// DONE  | z/co hold the finished result until the next start
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              co_q, co_d;
    logic              sum_bit;
    logic              carry_next;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

    always_comb begin
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

`ifdef SERIAL_ADDER_SUB_EN
        // Two's-complement subtract: invert y and inject a carry of one.
        b_load     = sub ? ~y : y;
        carry_load = sub ? 1'b1 : ci;
`else
        b_load     = y;
        carry_load = ci;
`endif

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = x;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    z_d     = '0;
                    co_d    = 1'b0;
                end
            end
            RUN: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                z_d          = z_q >> 1;
                z_d[WIDTH-1] = sum_bit;
                carry_d      = carry_next;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    co_d    = carry_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign z    = z_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner sequences, random vs. arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x, y;
    logic         ci;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy, done, co;
    logic [W-1:0] z;

    int n_pass = 0;
    int n_total = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .z     (z),
        .co    (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic [W-1:0] ez;
        logic         eco;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive a start pulse; returns at the negedge just after the accept edge.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic c, input logic s);
        @(negedge clk);
        start = 1'b1; x = xa; y = ya; ci = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub ignored in this build");
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts posedges until done; optionally scrambles inputs or injects a start on a given cycle.
    task automatic wait_done(input bit scramble, input int inject_at, output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            start = (cycles == inject_at);
            if (cycles == inject_at) begin
                x = 8'hAA; y = 8'hAA;
            end else if (scramble) begin
                x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [W:0] sum;
        logic [W-1:0] hold_z;
        logic hold_co;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_z", 32'(z), 0);
        chk("reset_co", 32'(co), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].x, vecs[i].y, vecs[i].ci, 1'b0);
            chk($sformatf("vec%0d_busy", i), 32'({busy, done}), 32'b10);
            wait_done(1'b0, 0, cyc);
            chk($sformatf("vec%0d_latency", i), 32'(cyc), W);
            chk($sformatf("vec%0d_z", i), 32'(z), 32'(vecs[i].ez));
            chk($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].eco));
        end

        // Hold in DONE with noisy inputs.
        hold_z = z; hold_co = co;
        repeat (4) begin
            @(negedge clk);
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
        end
        chk("hold_done", 32'(done), 1);
        chk("hold_z", 32'(z), 32'(hold_z));
        chk("hold_co", 32'(co), 32'(hold_co));

        // Back-to-back: start accepted directly from DONE.
        start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done(1'b0, 0, cyc);
        chk("b2b_first_z", 32'({co, z}), 32'h1FF);
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        chk("b2b_no_idle", 32'({busy, done}), 32'b10);
        wait_done(1'b0, 0, cyc);
        chk("b2b_latency", 32'(cyc), W);
        chk("b2b_second", 32'({co, z}), 32'h046);

        // Start during RUN is ignored.
        start_op(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(1'b0, 2, cyc);
        chk("ign_latency", 32'(cyc), W);
        chk("ign_result", 32'({co, z}), 32'h010);
        @(negedge clk);
        chk("ign_stays_done", 32'({busy, done}), 32'b01);

        // Reset mid-RUN aborts.
        start_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'({busy, done}), 0);
        chk("abort_result", 32'({co, z}), 0);
        // Reset wins over simultaneous start.
        start = 1'b1; x = 8'h01; y = 8'h01;
        @(negedge clk);
        chk("rst_over_start", 32'({busy, done}), 0);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'({busy, done}), 0);

        // Random operands, inputs scrambled while busy.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rx, ry;
            logic rc;
            rx = W'($urandom); ry = W'($urandom); rc = 1'($urandom);
            sum = {1'b0, rx} + {1'b0, ry} + {{W{1'b0}}, rc};
            start_op(rx, ry, rc, 1'b0);
            wait_done(1'b1, 0, cyc);
            chk($sformatf("rnd%0d_latency", i), 32'(cyc), W);
            chk($sformatf("rnd%0d_sum", i), 32'({co, z}), 32'(sum));
        end

`ifdef SERIAL_ADDER_SUB_EN
        start_op(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(1'b0, 0, cyc);
        chk("sub_5_7", 32'({co, z}), 32'h0FE);
        start_op(8'h07, 8'h05, 1'b0, 1'b1);
        wait_done(1'b0, 0, cyc);
        chk("sub_7_5", 32'({co, z}), 32'h102);
        sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits; legal range 1..32.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  load request; sampled on rising edge.
REQ-005 x  input  WIDTH  operand A; captured when start is accepted.
REQ-006 y  input  WIDTH  operand B; captured when start is accepted.
REQ-007 ci  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  high while z/co hold a completed result.
REQ-010 z  output  WIDTH  sum result.
REQ-011 co  output  1  carry-out of the most significant bit.

Function
REQ-012 Block SHALL be a bit-serial adder: one full-adder bit slice per cycle, LSB first, with one carry flip-flop.
REQ-013 Per-bit rule SHALL be: sum = a XOR b XOR c; next carry = majority(a, b, c).
REQ-014 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE or DONE with start=1 -> RUN; x, y load into shift registers, ci loads into carry flip-flop, bit counter loads 0, z clears to 0, done clears.
REQ-016 RUN: each cycle, consume bit 0 of both shift registers, shift the sum bit into z from the MSB end, update carry, increment counter.
REQ-017 RUN -> DONE on the cycle the counter reaches WIDTH-1; z then holds the full sum, co the final carry.
REQ-018 Latency SHALL be exactly WIDTH cycles from the start-accept edge to the edge that raises done.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-020 start during RUN SHALL be ignored; operands and the in-flight result SHALL be unaffected.
REQ-021 DONE SHALL hold z, co and done stable until the next accepted start or reset.
REQ-022 start in DONE SHALL clear done and raise busy on the same edge (back-to-back operation, no idle cycle).
REQ-023 Result SHALL equal (x + y + ci) mod 2^WIDTH in z with the carry out of bit WIDTH-1 in co.
REQ-024 WIDTH=1 SHALL complete in one RUN cycle.
REQ-025 x, y, ci changes while busy SHALL not affect the result.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, z=0, co=0, clear shift registers, carry and counter.
REQ-027 Reset SHALL override start when both are active on the same edge.
REQ-028 Reset during RUN SHALL abort the operation with no partial result visible afterwards.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN SHALL enable subtraction.
REQ-030 With SERIAL_ADDER_SUB_EN defined: extra input port sub (1 bit), captured at start; sub=1 loads ~y and forces the initial carry to 1 (ci ignored), giving z = (x - y) mod 2^WIDTH and co = 1 when no borrow (x >= y unsigned).
REQ-031 Without SERIAL_ADDER_SUB_EN: no sub port; behaviour is addition only as above.

Verification (WIDTH=8)
REQ-032 x=0x00, y=0x00, ci=0, start pulse -> busy for 8 cycles, then done=1, z=0x00, co=0.
REQ-033 x=0xFF, y=0x01, ci=0 -> done exactly 8 cycles after the accept edge, z=0x00, co=1.
REQ-034 x=0xFF, y=0xFF, ci=1 -> z=0xFF, co=1; then start with x=0x12, y=0x34, ci=0 in DONE -> z=0x46, co=0 with no idle cycle.
REQ-035 x=0x0F, y=0x01 start, then start with x=0xAA, y=0xAA on cycle 3 of RUN -> ignored, result z=0x10, co=0.
REQ-036 Start x=0xFF, y=0xFF, rst_n=0 on cycle 4 of RUN -> next cycle IDLE, busy=0, done=0, z=0x00, co=0.
REQ-037 With SERIAL_ADDER_SUB_EN: sub=1, x=0x05, y=0x07 -> z=0xFE, co=0; sub=1, x=0x07, y=0x05 -> z=0x02, co=1.
